// File: rtl/regfile_mp.sv
// Multi-ported register file: three combinational read ports with optional
// write-to-read forwarding, two write ports (port 1 wins on collision), a
// reservation port that marks registers as pending, a storage-only debug
// read port, and a registered pulse flagging same-address dual writes.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  input  logic [ADDR_W-1:0] i_rs3_addr,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  output logic [DATA_W-1:0] o_rs3_data,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy,
  output logic              o_rs3_busy,
  input  logic              i_wr0_en,
  input  logic [ADDR_W-1:0] i_wr0_addr,
  input  logic [DATA_W-1:0] i_wr0_data,
  input  logic              i_wr1_en,
  input  logic [ADDR_W-1:0] i_wr1_addr,
  input  logic [DATA_W-1:0] i_wr1_data,
  input  logic              i_rsv_en,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data,
  output logic              o_wr_conflict
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic                conflict_q;
  logic                conflict_d;

  logic wr0_ok;
  logic wr1_ok;
  logic rsv_ok;

  logic [ADDR_W-1:0] rd_addr [3];
  logic [DATA_W-1:0] rd_data [3];
  logic              rd_busy [3];

  // Address 0 is a constant-zero register when ZERO_REG is set.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr0_ok = i_wr0_en && !is_zero_reg(i_wr0_addr);
  assign wr1_ok = i_wr1_en && !is_zero_reg(i_wr1_addr);
  assign rsv_ok = i_rsv_en && !is_zero_reg(i_rsv_addr);

  // Collision only counts when both writes actually land in storage.
  assign conflict_d = wr0_ok && wr1_ok && (i_wr0_addr == i_wr1_addr);

  assign rd_addr[0] = i_rs1_addr;
  assign rd_addr[1] = i_rs2_addr;
  assign rd_addr[2] = i_rs3_addr;

  // Read ports: storage value, overridden by in-flight writes (port 1 first).
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_data[k] = regs_q[rd_addr[k]];
      rd_busy[k] = busy_q[rd_addr[k]];
      if (BYPASS != 0) begin
        if (wr1_ok && (i_wr1_addr == rd_addr[k])) begin
          rd_data[k] = i_wr1_data;
          rd_busy[k] = 1'b0;
        end else if (wr0_ok && (i_wr0_addr == rd_addr[k])) begin
          rd_data[k] = i_wr0_data;
          rd_busy[k] = 1'b0;
        end
      end
      if (is_zero_reg(rd_addr[k])) begin
        rd_data[k] = '0;
        rd_busy[k] = 1'b0;
      end
    end
  end

  assign o_rs1_data = rd_data[0];
  assign o_rs2_data = rd_data[1];
  assign o_rs3_data = rd_data[2];
  assign o_rs1_busy = rd_busy[0];
  assign o_rs2_busy = rd_busy[1];
  assign o_rs3_busy = rd_busy[2];

  // Debug port always shows committed storage, never forwarded data.
  assign o_dbg_data    = regs_q[i_dbg_addr];
  assign o_wr_conflict = conflict_q;

  // State update: writes clear pending, port 1 lands last so it wins,
  // and a reservation is applied after writes so a new producer keeps busy set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (wr0_ok) begin
        regs_q[i_wr0_addr] <= i_wr0_data;
        busy_q[i_wr0_addr] <= 1'b0;
      end
      if (wr1_ok) begin
        regs_q[i_wr1_addr] <= i_wr1_data;
        busy_q[i_wr1_addr] <= 1'b0;
      end
      if (rsv_ok) begin
        busy_q[i_rsv_addr] <= 1'b1;
      end
      conflict_q <= conflict_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (32 x 32, ZERO_REG=1, BYPASS=1): directed vector
// table, a full-file reset sequence, and randomized traffic against a model.
module tb_regfile_mp;

  logic        i_clk;
  logic        i_rst;
  logic [4:0]  i_rs1_addr, i_rs2_addr, i_rs3_addr;
  logic [31:0] o_rs1_data, o_rs2_data, o_rs3_data;
  logic        o_rs1_busy, o_rs2_busy, o_rs3_busy;
  logic        i_wr0_en, i_wr1_en, i_rsv_en;
  logic [4:0]  i_wr0_addr, i_wr1_addr, i_rsv_addr, i_dbg_addr;
  logic [31:0] i_wr0_data, i_wr1_data;
  logic [31:0] o_dbg_data;
  logic        o_wr_conflict;

  regfile_mp #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rs3_addr(i_rs3_addr),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_rs3_data(o_rs3_data),
    .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy), .o_rs3_busy(o_rs3_busy),
    .i_wr0_en(i_wr0_en), .i_wr0_addr(i_wr0_addr), .i_wr0_data(i_wr0_data),
    .i_wr1_en(i_wr1_en), .i_wr1_addr(i_wr1_addr), .i_wr1_data(i_wr1_data),
    .i_rsv_en(i_rsv_en), .i_rsv_addr(i_rsv_addr),
    .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data),
    .o_wr_conflict(o_wr_conflict)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: architectural register values, pending flags, pulse.
  logic [31:0] m_reg  [32];
  logic        m_busy [32];
  logic        m_conf;

  typedef struct {
    string       nm;
    logic        rst;
    logic        w0e;  logic [4:0] w0a; logic [31:0] w0d;
    logic        w1e;  logic [4:0] w1a; logic [31:0] w1d;
    logic        rsve; logic [4:0] rsva;
    logic [4:0]  r1, r2, r3, db;
    logic [31:0] e1;   logic b1;
    logic [31:0] e2;   logic b2;
    logic [31:0] e3;   logic b3;
    logic [31:0] edb;  logic ec;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(string nm, logic rst,
      logic w0e, int w0a, logic [31:0] w0d, logic w1e, int w1a, logic [31:0] w1d,
      logic rsve, int rsva, int r1, int r2, int r3, int db,
      logic [31:0] e1, logic b1, logic [31:0] e2, logic b2,
      logic [31:0] e3, logic b3, logic [31:0] edb, logic ec);
    vec_t v;
    v.nm = nm; v.rst = rst;
    v.w0e = w0e; v.w0a = 5'(w0a); v.w0d = w0d;
    v.w1e = w1e; v.w1a = 5'(w1a); v.w1d = w1d;
    v.rsve = rsve; v.rsva = 5'(rsva);
    v.r1 = 5'(r1); v.r2 = 5'(r2); v.r3 = 5'(r3); v.db = 5'(db);
    v.e1 = e1; v.b1 = b1; v.e2 = e2; v.b2 = b2; v.e3 = e3; v.b3 = b3;
    v.edb = edb; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    i_rst = 0; i_wr0_en = 0; i_wr1_en = 0; i_rsv_en = 0;
    i_wr0_addr = 0; i_wr1_addr = 0; i_rsv_addr = 0;
    i_wr0_data = 0; i_wr1_data = 0;
    i_rs1_addr = 0; i_rs2_addr = 0; i_rs3_addr = 0; i_dbg_addr = 0;
  endtask

  // Expected combinational read: zero register, then forwarded write
  // (port 1 preferred), otherwise the architectural value.
  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (i_wr1_en && i_wr1_addr == a) return i_wr1_data;
    if (i_wr0_en && i_wr0_addr == a) return i_wr0_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if ((i_wr1_en && i_wr1_addr == a) || (i_wr0_en && i_wr0_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  // Apply the clock-edge rules to the reference state using the held inputs.
  task automatic model_edge();
    if (i_rst) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_busy[i] = 0; end
      m_conf = 0;
    end else begin
      m_conf = i_wr0_en && i_wr1_en && (i_wr0_addr == i_wr1_addr) && (i_wr0_addr != 0);
      if (i_wr0_en && i_wr0_addr != 0) begin m_reg[i_wr0_addr] = i_wr0_data; m_busy[i_wr0_addr] = 0; end
      if (i_wr1_en && i_wr1_addr != 0) begin m_reg[i_wr1_addr] = i_wr1_data; m_busy[i_wr1_addr] = 0; end
      if (i_rsv_en && i_rsv_addr != 0) m_busy[i_rsv_addr] = 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " rs1_data"}, o_rs1_data, exp_data(i_rs1_addr));
    chk({tag, " rs2_data"}, o_rs2_data, exp_data(i_rs2_addr));
    chk({tag, " rs3_data"}, o_rs3_data, exp_data(i_rs3_addr));
    chk({tag, " rs1_busy"}, 32'(o_rs1_busy), 32'(exp_busy(i_rs1_addr)));
    chk({tag, " rs2_busy"}, 32'(o_rs2_busy), 32'(exp_busy(i_rs2_addr)));
    chk({tag, " rs3_busy"}, 32'(o_rs3_busy), 32'(exp_busy(i_rs3_addr)));
    chk({tag, " dbg_data"}, o_dbg_data, m_reg[i_dbg_addr]);
    chk({tag, " wr_conflict"}, 32'(o_wr_conflict), 32'(m_conf));
  endtask

  // Inputs are set at the falling edge; outputs sampled 1 time unit later.
  task automatic advance();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
  endtask

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    tbl[0]  = mk("wr_x5",      0, 1,5,32'hDEADBEEF, 0,0,0,       0,0, 5,7,3,5, 32'hDEADBEEF,0, 0,0, 0,0, 0,0);
    tbl[1]  = mk("rd_x5",      0, 0,0,0,            0,0,0,       0,0, 5,7,3,5, 32'hDEADBEEF,0, 0,0, 0,0, 32'hDEADBEEF,0);
    tbl[2]  = mk("dual_x7",    0, 1,7,32'h11,       1,7,32'h22,  0,0, 5,7,7,7, 32'hDEADBEEF,0, 32'h22,0, 32'h22,0, 0,0);
    tbl[3]  = mk("dual_after", 0, 0,0,0,            0,0,0,       0,0, 7,7,5,7, 32'h22,0, 32'h22,0, 32'hDEADBEEF,0, 32'h22,1);
    tbl[4]  = mk("rsv_x3",     0, 0,0,0,            0,0,0,       1,3, 3,7,3,7, 0,0, 32'h22,0, 0,0, 32'h22,0);
    tbl[5]  = mk("busy_x3",    0, 0,0,0,            0,0,0,       0,0, 3,3,3,3, 0,1, 0,1, 0,1, 0,0);
    tbl[6]  = mk("wr_x3",      0, 1,3,32'h55,       0,0,0,       0,0, 3,5,3,3, 32'h55,0, 32'hDEADBEEF,0, 32'h55,0, 0,0);
    tbl[7]  = mk("x3_after",   0, 0,0,0,            0,0,0,       0,0, 3,5,3,3, 32'h55,0, 32'hDEADBEEF,0, 32'h55,0, 32'h55,0);
    tbl[8]  = mk("zero_reg",   0, 1,0,32'hFFFFFFFF, 1,0,32'h1234, 1,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    tbl[9]  = mk("zero_after", 0, 0,0,0,            0,0,0,       0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    tbl[10] = mk("rsv_wr_x9",  0, 0,0,0,            1,9,32'h77,  1,9, 9,9,9,9, 32'h77,0, 32'h77,0, 32'h77,0, 0,0);
    tbl[11] = mk("x9_after",   0, 0,0,0,            0,0,0,       0,0, 9,9,9,9, 32'h77,1, 32'h77,1, 32'h77,1, 32'h77,0);
    tbl[12] = mk("rst_bypass", 1, 1,4,32'h99,       0,0,0,       1,4, 4,9,3,9, 32'h99,0, 32'h77,1, 32'h55,0, 32'h77,0);
    tbl[13] = mk("rst_after",  0, 0,0,0,            0,0,0,       0,0, 4,9,3,9, 0,0, 0,0, 0,0, 0,0);
    tbl[14] = mk("first_wr",   0, 1,6,32'hA5,       0,0,0,       0,0, 6,4,9,6, 32'hA5,0, 0,0, 0,0, 0,0);
    tbl[15] = mk("first_after",0, 0,0,0,            0,0,0,       0,0, 6,4,9,6, 32'hA5,0, 0,0, 0,0, 32'hA5,0);

    idle_inputs();
    i_rst = 1;
    @(negedge i_clk);
    advance();

    // Directed vectors with hand-derived expectations.
    for (int t = 0; t < 16; t++) begin
      i_rst = tbl[t].rst;
      i_wr0_en = tbl[t].w0e; i_wr0_addr = tbl[t].w0a; i_wr0_data = tbl[t].w0d;
      i_wr1_en = tbl[t].w1e; i_wr1_addr = tbl[t].w1a; i_wr1_data = tbl[t].w1d;
      i_rsv_en = tbl[t].rsve; i_rsv_addr = tbl[t].rsva;
      i_rs1_addr = tbl[t].r1; i_rs2_addr = tbl[t].r2; i_rs3_addr = tbl[t].r3;
      i_dbg_addr = tbl[t].db;
      #1;
      chk({tbl[t].nm, " rs1_data"}, o_rs1_data, tbl[t].e1);
      chk({tbl[t].nm, " rs2_data"}, o_rs2_data, tbl[t].e2);
      chk({tbl[t].nm, " rs3_data"}, o_rs3_data, tbl[t].e3);
      chk({tbl[t].nm, " rs1_busy"}, 32'(o_rs1_busy), 32'(tbl[t].b1));
      chk({tbl[t].nm, " rs2_busy"}, 32'(o_rs2_busy), 32'(tbl[t].b2));
      chk({tbl[t].nm, " rs3_busy"}, 32'(o_rs3_busy), 32'(tbl[t].b3));
      chk({tbl[t].nm, " dbg_data"}, o_dbg_data, tbl[t].edb);
      chk({tbl[t].nm, " wr_conflict"}, 32'(o_wr_conflict), 32'(tbl[t].ec));
      advance();
    end

    // Fill x1..x31 with nonzero values and reserve them, then reset with a
    // concurrent write and reservation; every register must come back clear.
    for (int a = 1; a < 32; a++) begin
      idle_inputs();
      i_wr0_en = 1; i_wr0_addr = 5'(a); i_wr0_data = 32'hC0DE_0000 | 32'(a);
      i_rsv_en = 1; i_rsv_addr = 5'(32 - a);
      i_rs1_addr = 5'(a); i_dbg_addr = 5'(a - 1);
      #1;
      check_model("fill");
      advance();
    end
    idle_inputs();
    i_rst = 1; i_wr0_en = 1; i_wr0_addr = 4; i_wr0_data = 32'h99;
    i_rsv_en = 1; i_rsv_addr = 4;
    advance();
    for (int a = 0; a < 32; a++) begin
      idle_inputs();
      i_rs1_addr = 5'(a); i_rs2_addr = 5'(a); i_rs3_addr = 5'(a); i_dbg_addr = 5'(a);
      #1;
      chk("post_rst rs1_data", o_rs1_data, 32'h0);
      chk("post_rst rs1_busy", 32'(o_rs1_busy), 32'h0);
      chk("post_rst dbg_data", o_dbg_data, 32'h0);
      check_model("post_rst");
      advance();
    end

    // Randomized traffic with frequent address collisions.
    for (int c = 0; c < 3000; c++) begin
      i_rst      = ($urandom_range(0, 63) == 0);
      i_wr0_en   = 1'($urandom_range(0, 1));
      i_wr0_addr = raddr();
      i_wr0_data = $urandom;
      i_wr1_en   = 1'($urandom_range(0, 1));
      i_wr1_addr = raddr();
      i_wr1_data = $urandom;
      i_rsv_en   = 1'($urandom_range(0, 1));
      i_rsv_addr = raddr();
      i_rs1_addr = raddr();
      i_rs2_addr = raddr();
      i_rs3_addr = raddr();
      i_dbg_addr = raddr();
      #1;
      check_model("rand");
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
